// File: rtl/token_writer.sv
// Keypad-side token writer: validated tokens into a DEPTH-entry store, '#'-terminated.
// Optional syntax checking is enabled by TOKEN_WRITER_STRICT_SYNTAX_EN.
module token_writer #(
  parameter int          DEPTH = 100,
  parameter int          AW    = 7,
  parameter logic [7:0]  TERM  = 8'd10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_token,
  input  logic          clear,
  output logic          done,
  output logic [AW-1:0] len,
  output logic          err,
  input  logic [AW-1:0] rd_index,
  output logic [7:0]    rd_token
);

`ifdef TOKEN_WRITER_STRICT_SYNTAX_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  localparam logic [AW-1:0] FULL_AT = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic          last_op_q, last_op_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [7:0]    mem_q [DEPTH];

  logic is_dig, is_op, is_term, is_legal;
  logic full, xfer, ok, wr_en;

  assign is_dig   = (in_token <= 8'd9);
  assign is_op    = (in_token >= 8'd20) && (in_token <= 8'd23);
  assign is_term  = (in_token == TERM);
  assign is_legal = is_dig | is_op | is_term;
  assign full     = (len_q == FULL_AT);

  assign in_ready = (state_q != DONE) && !clear;
  assign xfer     = in_valid && in_ready;

  // Once only the terminator slot is left, nothing but TERM fits.
  always_comb begin
    ok = 1'b0;
    if (is_legal) begin
      if (state_q == IDLE)
        ok = is_dig | (is_op & !STRICT);
      else if (full)
        ok = is_term;
      else
        ok = is_dig | !(STRICT & last_op_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    last_op_d = last_op_q;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      len_d     = '0;
      last_op_d = 1'b0;
    end else if (xfer) begin
      if (ok) begin
        wr_en     = 1'b1;
        len_d     = len_q + 1'b1;
        last_op_d = is_op;
        state_d   = is_term ? DONE : FILL;
      end else begin
        err_d = 1'b1;
      end
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      last_op_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      last_op_q <= last_op_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Contents survive reset; len masks stale entries on the read port.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[len_q] <= in_token;
  end

  assign done     = done_q;
  assign len      = len_q;
  assign err      = err_q;
  assign rd_token = (rd_index < len_q) ? mem_q[rd_index] : TERM;

endmodule

// File: tb/tb_token_writer.sv
// Randomized bench for token_writer against a list-based model of the token store.
// Directed sequences pin the model with hand-computed values.
module tb_token_writer;

  localparam int DEPTH = 100;
  localparam int AW    = 7;

`ifdef TOKEN_WRITER_STRICT_SYNTAX_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_token = 8'd0;
  logic          clear = 1'b0;
  logic          done;
  logic [AW-1:0] len;
  logic          err;
  logic [AW-1:0] rd_index = '0;
  logic [7:0]    rd_token;

  token_writer #(.DEPTH(DEPTH), .AW(AW), .TERM(8'd10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_token(in_token),
    .clear(clear), .done(done), .len(len), .err(err),
    .rd_index(rd_index), .rd_token(rd_token)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model: the stored expression as a plain list.
  int m_mem[$];
  bit m_done;
  bit m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tok_is_op(input int t);
    return t >= 20 && t <= 23;
  endfunction

  function automatic bit accepts(input int t);
    int n;
    bit lastop;
    n = m_mem.size();
    lastop = (n > 0) && tok_is_op(m_mem[n-1]);
    if (!(t <= 9 || t == 10 || tok_is_op(t))) return 0;
    if (n == DEPTH - 1) return t == 10;
    if (n == 0) return (t <= 9) || (tok_is_op(t) && !STRICT);
    if (t <= 9) return 1;
    return !(STRICT && lastop);
  endfunction

  task automatic model_update(input bit v, input int t, input bit c);
    m_err = 0;
    if (c) begin
      m_mem.delete();
      m_done = 0;
    end else if (v && !m_done) begin
      if (accepts(t)) begin
        m_mem.push_back(t);
        if (t == 10) m_done = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  function automatic int exp_rd(input int idx);
    return (idx < m_mem.size()) ? m_mem[idx] : 10;
  endfunction

  // One clock of stimulus followed by the full output comparison.
  task automatic step(input bit v, input int t, input bit c);
    in_valid = v;
    in_token = 8'(t);
    clear    = c;
    #1 chk("in_ready", int'(in_ready), int'(!m_done && !c));
    @(posedge clk);
    model_update(v, t, c);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    rd_index = AW'($urandom_range(0, 127));
    #1;
    chk("len", int'(len), m_mem.size());
    chk("done", int'(done), int'(m_done));
    chk("err", int'(err), int'(m_err));
    chk("rd_token", int'(rd_token), exp_rd(int'(rd_index)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_len", int'(len), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    m_mem.delete();
    m_done = 0;
    m_err  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic peek(input string name, input int idx, input int exp);
    rd_index = AW'(idx);
    #1 chk(name, int'(rd_token), exp);
  endtask

  int seq1[8] = '{1, 5, 21, 1, 0, 20, 9, 10};

  initial begin
    @(negedge clk);
    do_reset();

    // Expression 1,5,*,1,0,+,9,#
    foreach (seq1[i]) step(1, seq1[i], 0);
    chk("t1_len", int'(len), 8);
    chk("t1_done", int'(done), 1);
    for (int i = 0; i < 8; i++) peek("t1_rd", i, seq1[i]);
    peek("t1_rd8", 8, 10);

    // DONE holds against a waiting token
    for (int i = 0; i < 5; i++) begin
      step(1, 2, 0);
      chk("t6_ready", int'(in_ready), 0);
      chk("t6_len", int'(len), 8);
      chk("t6_err", int'(err), 0);
    end
    peek("t6_rd3", 3, 1);

    // Illegal code in FILL
    step(0, 0, 1);
    step(1, 4, 0);
    step(1, 15, 0);
    chk("t2_err", int'(err), 1);
    chk("t2_len", int'(len), 1);
    chk("t2_ready", int'(in_ready), 1);
    step(1, 3, 0);
    chk("t2_len3", int'(len), 2);
    peek("t2_rd1", 1, 3);

    // Syntax sequences
    step(0, 0, 1);
    step(1, 20, 0);
    chk("t3a_len", int'(len), STRICT ? 0 : 1);
    chk("t3a_err", int'(err), STRICT ? 1 : 0);
    step(0, 0, 1);
    step(1, 1, 0); step(1, 20, 0); step(1, 21, 0);
    chk("t3b_len", int'(len), STRICT ? 2 : 3);
    chk("t3b_err", int'(err), STRICT ? 1 : 0);
    step(0, 0, 1);
    step(1, 1, 0); step(1, 20, 0); step(1, 10, 0);
    chk("t3c_done", int'(done), STRICT ? 0 : 1);
    chk("t3c_len", int'(len), STRICT ? 2 : 3);

    // Fill to capacity
    step(0, 0, 1);
    for (int i = 0; i < 99; i++) step(1, i % 10, 0);
    chk("t4_len99", int'(len), 99);
    step(1, 4, 0);
    chk("t4_err", int'(err), 1);
    chk("t4_len", int'(len), 99);
    step(1, 10, 0);
    chk("t4_len100", int'(len), 100);
    chk("t4_done", int'(done), 1);
    peek("t4_rd99", 99, 10);
    peek("t4_rd98", 98, 8);

    // clear beats a same-cycle transfer
    step(0, 0, 1);
    step(1, 6, 0);
    step(1, 7, 1);
    chk("t5_len", int'(len), 0);
    chk("t5_ready", int'(in_ready), 1);
    step(1, 20, 0);
    chk("t5_idle", int'(len), STRICT ? 0 : 1);

    // Asynchronous reset mid-FILL
    step(1, 2, 0);
    #2 do_reset();
    chk("t5_async_len", int'(len), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r, t;
      r = $urandom_range(0, 99);
      if (r < 50) t = $urandom_range(0, 9);
      else if (r < 75) t = $urandom_range(20, 23);
      else if (r < 82) t = 10;
      else if (r < 90) t = $urandom_range(11, 19);
      else t = $urandom_range(24, 255);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, t, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
